wb_rr_arbiter: RTL
==================

Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone arbiter that shares one slave port between NUM_MASTERS bus masters, e.g. CPU data port and DMA masters contending for the scratchpad or RAM.
- Sits between the masters and a single slave (or an interconnect slave port). It owns grant, bus-lock and watchdog sequencing.
- A hung slave cycle is terminated with an error so that one master cannot lock the shared resource indefinitely.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- WB_ADDR_WIDTH, 32, address width.
- WB_DATA_WIDTH, 32, data width; select width is WB_DATA_WIDTH/8.
- TIMEOUT, 255, number of cycles with stb asserted and no ack/err before the watchdog fires (1..65535).

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- m_cyc  in  NUM_MASTERS  per-master cyc.
- m_stb  in  NUM_MASTERS  per-master stb.
- m_we  in  NUM_MASTERS  per-master we.
- m_adr  in  NUM_MASTERS*WB_ADDR_WIDTH  packed addresses; master i at slice i.
- m_dat_w  in  NUM_MASTERS*WB_DATA_WIDTH  packed write data.
- m_sel  in  NUM_MASTERS*WB_DATA_WIDTH/8  packed byte selects.
- m_dat_r  out  WB_DATA_WIDTH  read data, broadcast to all masters.
- m_ack  out  NUM_MASTERS  per-master ack.
- m_err  out  NUM_MASTERS  per-master err.
- s_cyc, s_stb, s_we  out  1 each  slave-side controls.
- s_adr  out  WB_ADDR_WIDTH  slave address.
- s_dat_w  out  WB_DATA_WIDTH  slave write data.
- s_sel  out  WB_DATA_WIDTH/8  slave byte selects.
- s_dat_r  in  WB_DATA_WIDTH  slave read data.
- s_ack, s_err  in  1 each  slave termination.
- grant  out  NUM_MASTERS  one-hot current owner; all-zero when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset values:
  - rstn low clears everything immediately, without waiting for a clock edge: grant=0, s_cyc=0, s_stb=0, m_ack=0, m_err=0, timeout_o=0, last-owner pointer=NUM_MASTERS-1, watchdog=0.
  - Reset asserted mid-transfer abandons the transfer; the slave sees cyc drop asynchronously.
- FSM states: IDLE, OWN.
- IDLE:
  - If any m_cyc is high, select the first requesting index searching upward from (last+1), wrapping modulo NUM_MASTERS.
  - Register the selection as the one-hot grant and move to OWN.
  - Grant latency: the cycle after m_cyc rises.
  - If no m_cyc is high, stay in IDLE with grant=0.
- OWN:
  - Lock rule: the grant is held while m_cyc[owner]=1, irrespective of other requests. Multi-beat and RMW cycles are never split.
  - When m_cyc[owner] falls: go to IDLE, set last=owner, clear grant. This always gives one idle cycle between owners, and the next owner is granted one cycle later.
- Datapath, combinational from the registered grant:
  - s_cyc = m_cyc[owner] & in OWN.
  - s_stb = m_stb[owner] & s_cyc & ~wd_kill.
  - s_we, s_adr, s_dat_w and s_sel are muxed from the owner's slice; they are all zero when idle.
  - m_ack[i] = s_ack & grant[i] & s_stb.
  - m_err[i] = (s_err & grant[i] & s_stb) | watchdog error (below).
  - m_dat_r = s_dat_r, unqualified.
  - A non-owner never sees ack or err.
- Watchdog:
  - 16-bit counter. It increments each cycle s_stb=1 and s_ack=s_err=0.
  - It clears on ack, on err, or when s_stb=0.
  - When the count reaches TIMEOUT, for exactly one cycle:
    - assert m_err[owner] and timeout_o;
    - assert wd_kill, which forces s_stb=0 for that cycle;
    - clear the counter.
  - Ownership is unchanged; the master decides whether to drop cyc.
  - If s_ack arrives in the same cycle the count reaches TIMEOUT, ack wins: no err, no timeout_o.
- Simultaneous events:
  - If all masters request in the same cycle, rotation guarantees each is served within NUM_MASTERS ownership periods.
  - A request from the releasing owner in the cycle after release is ranked last.
- Arithmetic:
  - The pointer wraps modulo NUM_MASTERS. Non-power-of-two counts are handled by explicit compare, not truncation.

Test Plan:
- Reset, then m_cyc=4'b0100 -> grant=4'b0100 on the next cycle; s_adr equals the master 2 slice; a single ack is routed only to m_ack[2].
- m_cyc=4'b1111 held, each master releases after one ack -> grant sequence 0001, 0010, 0100, 1000, 0001, with one idle (grant=0) cycle between owners.
- Master 1 holds cyc across 3 stb/ack beats while master 0 requests -> grant stays 0010 for all 3 beats; master 0 is granted 2 cycles after master 1 drops cyc.
- TIMEOUT=8, slave never acks -> after 8 stalled cycles: m_err[owner]=1 and timeout_o=1 for 1 cycle, s_stb=0 for that cycle, then the counter restarts. Also: ack on cycle 8 -> no err.
- rstn pulsed low mid-transfer with no clock edge -> s_cyc and grant go to 0 within the same time step; after release, master 0 gets first grant when all masters request.
- s_err from the slave during master 3's cycle -> m_err[3] only; ownership is kept until m_cyc[3] falls.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port.
// Ownership locks for the whole cyc; a watchdog errors out stalled strobes.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS   = 4,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int TIMEOUT       = 255
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic [NUM_MASTERS-1:0]                  m_cyc,
  input  logic [NUM_MASTERS-1:0]                  m_stb,
  input  logic [NUM_MASTERS-1:0]                  m_we,
  input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0]    m_adr,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]    m_dat_w,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH/8-1:0]  m_sel,
  output logic [WB_DATA_WIDTH-1:0]                m_dat_r,
  output logic [NUM_MASTERS-1:0]                  m_ack,
  output logic [NUM_MASTERS-1:0]                  m_err,
  output logic                                    s_cyc,
  output logic                                    s_stb,
  output logic                                    s_we,
  output logic [WB_ADDR_WIDTH-1:0]                s_adr,
  output logic [WB_DATA_WIDTH-1:0]                s_dat_w,
  output logic [WB_DATA_WIDTH/8-1:0]              s_sel,
  input  logic [WB_DATA_WIDTH-1:0]                s_dat_r,
  input  logic                                    s_ack,
  input  logic                                    s_err,
  output logic [NUM_MASTERS-1:0]                  grant,
  output logic                                    timeout_o
);

  localparam int SEL_W = WB_DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IDX_W:0]          NM_C        = (IDX_W+1)'(NUM_MASTERS);
  localparam logic [IDX_W-1:0]        LAST_INIT_C = IDX_W'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0]  ONE_HOT0_C  = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [15:0]             TIMEOUT_C   = 16'(TIMEOUT);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_e;

  state_e                    state_r;
  logic [NUM_MASTERS-1:0]    grant_r;
  logic [IDX_W-1:0]          owner_r;
  logic [IDX_W-1:0]          last_r;
  logic [15:0]               wd_cnt_r;

  logic                      pick_valid_s;
  logic [IDX_W-1:0]          pick_idx_s;
  logic [IDX_W:0]            cand_s;
  logic                      owner_cyc_s;
  logic                      owner_stb_s;
  logic                      wd_kill_s;
  logic                      s_we_s;
  logic [WB_ADDR_WIDTH-1:0]  s_adr_s;
  logic [WB_DATA_WIDTH-1:0]  s_dat_w_s;
  logic [SEL_W-1:0]          s_sel_s;

  // Round-robin search upward from last+1; explicit wrap keeps non-power-of-two counts exact
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand_s = {1'b0, last_r} + (IDX_W+1)'(k);
      if (cand_s >= NM_C) begin
        cand_s = cand_s - NM_C;
      end else begin
        cand_s = cand_s;
      end
      if (!pick_valid_s && m_cyc[cand_s[IDX_W-1:0]]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = cand_s[IDX_W-1:0];
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // Owner slice mux: AND-OR on the one-hot grant yields zeros while idle
  always_comb begin
    s_we_s    = 1'b0;
    s_adr_s   = '0;
    s_dat_w_s = '0;
    s_sel_s   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      s_we_s    = s_we_s    | (grant_r[i] & m_we[i]);
      s_adr_s   = s_adr_s   | ({WB_ADDR_WIDTH{grant_r[i]}} & m_adr[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]);
      s_dat_w_s = s_dat_w_s | ({WB_DATA_WIDTH{grant_r[i]}} & m_dat_w[i*WB_DATA_WIDTH +: WB_DATA_WIDTH]);
      s_sel_s   = s_sel_s   | ({SEL_W{grant_r[i]}} & m_sel[i*SEL_W +: SEL_W]);
    end
  end

  assign owner_cyc_s = |(m_cyc & grant_r);
  assign owner_stb_s = |(m_stb & grant_r);

  assign s_cyc     = (state_r == ST_OWN) & owner_cyc_s;
  // An ack landing on the terminal count completes the beat instead of timing out
  assign wd_kill_s = (wd_cnt_r == TIMEOUT_C) & owner_stb_s & s_cyc & ~s_ack;
  assign s_stb     = owner_stb_s & s_cyc & ~wd_kill_s;
  assign s_we      = s_we_s;
  assign s_adr     = s_adr_s;
  assign s_dat_w   = s_dat_w_s;
  assign s_sel     = s_sel_s;

  assign m_dat_r   = s_dat_r;
  assign m_ack     = grant_r & {NUM_MASTERS{s_ack & s_stb}};
  assign m_err     = grant_r & {NUM_MASTERS{(s_err & s_stb) | wd_kill_s}};
  assign grant     = grant_r;
  assign timeout_o = wd_kill_s;

  // Grant FSM: owner keeps the bus until its own cyc drops
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      owner_r <= '0;
      last_r  <= LAST_INIT_C;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            state_r <= ST_OWN;
            grant_r <= ONE_HOT0_C << pick_idx_s;
            owner_r <= pick_idx_s;
          end else begin
            grant_r <= '0;
          end
        end
        ST_OWN: begin
          if (!owner_cyc_s) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            last_r  <= owner_r;
          end else begin
            grant_r <= grant_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= '0;
        end
      endcase
    end
  end

  // Watchdog: counts stalled strobe cycles, restarts on any termination or idle strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt_r <= 16'd0;
    end else if (s_stb && !s_ack && !s_err) begin
      wd_cnt_r <= wd_cnt_r + 16'd1;
    end else begin
      wd_cnt_r <= 16'd0;
    end
  end

endmodule
